// File: rtl/pipeline_ctrl.sv
`default_nettype none
// pipeline_ctrl - per-stage write-enable / bubble controller for IF/ID..MEM/WB and the PC.
// Define PIPECTRL_TIMEOUT_EN to build the memory-wait watchdog and the HALT state.
module pipeline_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_use,
  input  logic       branch_taken,
  input  logic       imem_req,
  input  logic       imem_ready,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic [3:0] we,
  output logic [3:0] clear,
  output logic       pc_we,
  output logic       stalled,
  output logic [1:0] state,
  output logic       timeout
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t     cur_state, eval_next, base_next, next_state;
  logic [3:0] eval_we, eval_clear, base_we, base_clear;
  logic       eval_pc_we, base_pc_we;
  logic       data_miss, fetch_miss, waiting;

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("pipeline_ctrl: TIMEOUT_W must be at least 1");
  end

  assign data_miss  = dmem_req & ~dmem_ready;
  assign fetch_miss = imem_req & ~imem_ready;
  assign waiting    = (cur_state == WAIT_I) || (cur_state == WAIT_D);

  // RUN priority list. WAIT_I evaluates the same list, and on the WAIT_D ready
  // cycle data_miss is already low, so the data rule is masked for free.
  always_comb begin
    eval_we    = 4'b1111;
    eval_clear = 4'b0000;
    eval_pc_we = 1'b1;
    eval_next  = RUN;
    if (data_miss) begin
      eval_we    = 4'b1000;
      eval_clear = 4'b1000;
      eval_pc_we = 1'b0;
      eval_next  = WAIT_D;
    end else if (branch_taken) begin
      eval_clear = 4'b0011;
    end else if (fetch_miss) begin
      eval_clear = 4'b0001;
      eval_pc_we = 1'b0;
      eval_next  = WAIT_I;
    end else if (load_use) begin
      eval_we    = 4'b1110;
      eval_clear = 4'b0010;
      eval_pc_we = 1'b0;
    end
  end

  always_comb begin
    base_we    = eval_we;
    base_clear = eval_clear;
    base_pc_we = eval_pc_we;
    base_next  = eval_next;
    case (cur_state)
      WAIT_D: begin
        if (!dmem_ready) begin
          base_we    = 4'b1000;
          base_clear = 4'b1000;
          base_pc_we = 1'b0;
          base_next  = WAIT_D;
        end
      end
      HALT: begin
        base_we    = 4'b0000;
        base_clear = 4'b0000;
        base_pc_we = 1'b0;
        base_next  = HALT;
      end
      default: ;
    endcase
  end

`ifdef PIPECTRL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timeout_q;
  logic                 expire;

  // wait_cnt holds completed wait cycles, so the limit trips on the (2^W-1)th one
  assign expire     = waiting && (base_next != RUN) && (wait_cnt == CNT_MAX - CNT_ONE);
  assign next_state = expire ? HALT : base_next;
  assign timeout    = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (next_state == RUN)
        wait_cnt <= '0;
      else if (waiting && (wait_cnt != CNT_MAX))
        wait_cnt <= wait_cnt + CNT_ONE;
      if (expire)
        timeout_q <= 1'b1;
    end
  end
`else
  assign next_state = base_next;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cur_state <= RUN;
    else
      cur_state <= next_state;
  end

  always_comb begin
    if (!reset) begin
      we    = 4'b0000;
      clear = 4'b1111;
      pc_we = 1'b0;
    end else begin
      we    = base_we;
      clear = base_clear;
      pc_we = base_pc_we;
    end
  end

  assign stalled = reset & ~pc_we;
  assign state   = cur_state;

endmodule
`default_nettype wire
